// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the execute stage and the branch resolve unit.
// The master side issues branch requests; the slave side returns resolved results and counters.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;

  logic             out_valid;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             breq;
  logic             brlt;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output in_valid, stall, flush, funct3, rs1_data, rs2_data, pc, imm,
    input  out_valid, taken, target, breq, brlt, illegal, br_count, taken_count
  );

  modport slave (
    input  in_valid, stall, flush, funct3, rs1_data, rs2_data, pc, imm,
    output out_valid, taken, target, breq, brlt, illegal, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// RV32I conditional-branch resolver: compare, condition decode, target add, 1- or 2-deep
// pipeline with stall/flush, plus saturating retired-branch and taken-branch counters.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  // Operands feeding the compare logic: either the raw inputs or the stage-1 copy
  logic            c_valid;
  logic [2:0]      c_funct3;
  logic [XLEN-1:0] c_rs1;
  logic [XLEN-1:0] c_rs2;
  logic [XLEN-1:0] c_pc;
  logic [XLEN-1:0] c_imm;

  generate
    if (LATENCY == 2) begin : g_stage1
      logic            s1_valid_reg;
      logic [2:0]      s1_funct3_reg;
      logic [XLEN-1:0] s1_rs1_reg;
      logic [XLEN-1:0] s1_rs2_reg;
      logic [XLEN-1:0] s1_pc_reg;
      logic [XLEN-1:0] s1_imm_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid_reg <= 1'b0;
        end else if (bus.flush) begin
          s1_valid_reg <= 1'b0;
        end else if (!bus.stall) begin
          s1_valid_reg <= bus.in_valid;
        end
      end

      // Payload needs no reset: it is only observed behind s1_valid_reg
      always_ff @(posedge clk) begin
        if (!bus.stall) begin
          s1_funct3_reg <= bus.funct3;
          s1_rs1_reg    <= bus.rs1_data;
          s1_rs2_reg    <= bus.rs2_data;
          s1_pc_reg     <= bus.pc;
          s1_imm_reg    <= bus.imm;
        end
      end

      assign c_valid  = s1_valid_reg;
      assign c_funct3 = s1_funct3_reg;
      assign c_rs1    = s1_rs1_reg;
      assign c_rs2    = s1_rs2_reg;
      assign c_pc     = s1_pc_reg;
      assign c_imm    = s1_imm_reg;
    end else begin : g_direct
      assign c_valid  = bus.in_valid;
      assign c_funct3 = bus.funct3;
      assign c_rs1    = bus.rs1_data;
      assign c_rs2    = bus.rs2_data;
      assign c_pc     = bus.pc;
      assign c_imm    = bus.imm;
    end
  endgenerate

  logic            eq_next;
  logic            lt_next;
  logic            cond_next;
  logic            illegal_next;
  logic            taken_next;
  logic [XLEN-1:0] target_next;

  always_comb begin
    eq_next      = (c_rs1 == c_rs2);
    // funct3[1] selects the unsigned flavour (BLTU/BGEU)
    lt_next      = c_funct3[1] ? (c_rs1 < c_rs2) : ($signed(c_rs1) < $signed(c_rs2));
    illegal_next = (c_funct3[2:1] == 2'b01);
    cond_next    = 1'b0;
    case (c_funct3)
      3'b000:         cond_next = eq_next;
      3'b001:         cond_next = !eq_next;
      3'b100, 3'b110: cond_next = lt_next;
      3'b101, 3'b111: cond_next = !lt_next;
      default:        cond_next = 1'b0;
    endcase
    taken_next  = cond_next & ~illegal_next;
    target_next = c_pc + c_imm;
  end

  logic            valid_reg;
  logic            taken_reg;
  logic            breq_reg;
  logic            brlt_reg;
  logic            illegal_reg;
  logic [XLEN-1:0] target_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      taken_reg   <= 1'b0;
      breq_reg    <= 1'b0;
      brlt_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      target_reg  <= '0;
    end else if (bus.flush) begin
      valid_reg   <= 1'b0;
    end else if (!bus.stall) begin
      valid_reg   <= c_valid;
      taken_reg   <= taken_next;
      breq_reg    <= eq_next;
      brlt_reg    <= lt_next;
      illegal_reg <= illegal_next;
      target_reg  <= target_next;
    end
  end

  // A result retires on any edge where it is presented and not stalled
  logic             retire;
  logic [1:0]       cnt_hit;
  logic [CNT_W-1:0] cnt_val [2];

  assign retire  = valid_reg & ~bus.stall;
  assign cnt_hit = {retire & taken_reg, retire};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign bus.out_valid   = valid_reg;
  assign bus.taken       = taken_reg;
  assign bus.target      = target_reg;
  assign bus.breq        = breq_reg;
  assign bus.brlt        = brlt_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.br_count    = cnt_val[0];
  assign bus.taken_count = cnt_val[1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: three instances cover LATENCY=1, LATENCY=2
// and a 4-bit counter width; results are queued at issue and compared at retirement.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus1 ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus2 ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(4))  bus3 ();

  branch_resolve_unit #(.XLEN(32), .LATENCY(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  branch_resolve_unit #(.XLEN(32), .LATENCY(2), .CNT_W(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  branch_resolve_unit #(.XLEN(32), .LATENCY(1), .CNT_W(4))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct packed {
    logic        taken;
    logic        breq;
    logic        brlt;
    logic        illegal;
    logic [31:0] target;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_br [3];
  int   exp_tk [3];

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, b, p, im);
    exp_t m;
    logic lt;
    m.breq    = (a == b);
    lt        = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    m.brlt    = lt;
    m.illegal = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:  m.taken = m.breq;
      3'b001:  m.taken = !m.breq;
      3'b100:  m.taken = lt;
      3'b110:  m.taken = lt;
      3'b101:  m.taken = !lt;
      3'b111:  m.taken = !lt;
      default: m.taken = 1'b0;
    endcase
    m.target = p + im;
    return m;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, st, fl, input logic [2:0] f3,
                       input logic [31:0] a, b, p, im);
    case (id)
      0: begin
        bus1.in_valid = v; bus1.stall = st; bus1.flush = fl; bus1.funct3 = f3;
        bus1.rs1_data = a; bus1.rs2_data = b; bus1.pc = p; bus1.imm = im;
      end
      1: begin
        bus2.in_valid = v; bus2.stall = st; bus2.flush = fl; bus2.funct3 = f3;
        bus2.rs1_data = a; bus2.rs2_data = b; bus2.pc = p; bus2.imm = im;
      end
      default: begin
        bus3.in_valid = v; bus3.stall = st; bus3.flush = fl; bus3.funct3 = f3;
        bus3.rs1_data = a; bus3.rs2_data = b; bus3.pc = p; bus3.imm = im;
      end
    endcase
  endtask

  task automatic send(input int id, input logic [2:0] f3, input logic [31:0] a, b, p, im);
    exp_t e;
    drive(id, 1'b1, 1'b0, 1'b0, f3, a, b, p, im);
    e = model(f3, a, b, p, im);
    case (id)
      0:       q1.push_back(e);
      1:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic idle(input int id);
    drive(id, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Retirement monitor: a presented, unstalled result must match the oldest queued one
  task automatic mon(input int id, input logic ov, st, tk, eq, lt, il, input logic [31:0] tg);
    exp_t e;
    int   sz;
    int   mx;
    if (ov && !st) begin
      n_checks++;
      case (id)
        0:       sz = q1.size();
        1:       sz = q2.size();
        default: sz = q3.size();
      endcase
      if (sz == 0) begin
        n_fail++;
        $display("FAIL mon%0d_unexpected: got result tgt=%h with nothing outstanding", id, tg);
      end else begin
        case (id)
          0:       e = q1.pop_front();
          1:       e = q2.pop_front();
          default: e = q3.pop_front();
        endcase
        if ({tk, eq, lt, il, tg} !== e) begin
          n_fail++;
          $display("FAIL mon%0d_result: got tk=%b eq=%b lt=%b il=%b tgt=%h want tk=%b eq=%b lt=%b il=%b tgt=%h",
                   id, tk, eq, lt, il, tg, e.taken, e.breq, e.brlt, e.illegal, e.target);
        end
        mx = (id == 2) ? 15 : 65535;
        if (exp_br[id] < mx) exp_br[id]++;
        if (e.taken && exp_tk[id] < mx) exp_tk[id]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(0, bus1.out_valid, bus1.stall, bus1.taken, bus1.breq, bus1.brlt, bus1.illegal, bus1.target);
      mon(1, bus2.out_valid, bus2.stall, bus2.taken, bus2.breq, bus2.brlt, bus2.illegal, bus2.target);
      mon(2, bus3.out_valid, bus3.stall, bus3.taken, bus3.breq, bus3.brlt, bus3.illegal, bus3.target);
    end
  end

  task automatic clear_model();
    q1.delete(); q2.delete(); q3.delete();
    for (int i = 0; i < 3; i++) begin
      exp_br[i] = 0;
      exp_tk[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(0); idle(1); idle(2);
    cycle();
    cycle();
    clear_model();
    n_checks++;
    if ({bus1.out_valid, bus1.taken, bus1.breq, bus1.brlt, bus1.illegal} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags1: got %b want 00000",
        {bus1.out_valid, bus1.taken, bus1.breq, bus1.brlt, bus1.illegal});
    end
    n_checks++;
    if (bus1.target !== 32'h0) begin n_fail++; $display("FAIL reset_target1: got %h want 0", bus1.target); end
    n_checks++;
    if ({bus1.br_count, bus1.taken_count} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts1: got %h/%h want 0/0", bus1.br_count, bus1.taken_count);
    end
    n_checks++;
    if ({bus2.out_valid, bus2.taken, bus2.breq, bus2.brlt, bus2.illegal} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags2: got %b want 00000",
        {bus2.out_valid, bus2.taken, bus2.breq, bus2.brlt, bus2.illegal});
    end
    n_checks++;
    if (bus2.target !== 32'h0) begin n_fail++; $display("FAIL reset_target2: got %h want 0", bus2.target); end
    n_checks++;
    if ({bus2.br_count, bus2.taken_count} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts2: got %h/%h want 0/0", bus2.br_count, bus2.taken_count);
    end
    n_checks++;
    if ({bus3.out_valid, bus3.taken, bus3.target, bus3.br_count, bus3.taken_count} !== 42'h0) begin
      n_fail++; $display("FAIL reset_all3: got v=%b t=%b tgt=%h cnt=%h/%h want all 0",
        bus3.out_valid, bus3.taken, bus3.target, bus3.br_count, bus3.taken_count);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_beq_blt();
    send(0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h10);
    cycle();
    n_checks++;
    if ({bus1.out_valid, bus1.taken, bus1.breq, bus1.brlt} !== 4'b1110) begin
      n_fail++; $display("FAIL beq_flags: got v/t/eq/lt=%b want 1110",
        {bus1.out_valid, bus1.taken, bus1.breq, bus1.brlt});
    end
    send(0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h104, 32'hFFFF_FFF8);
    cycle();
    n_checks++;
    if ({bus1.out_valid, bus1.taken, bus1.brlt} !== 3'b111 || bus1.target !== 32'h0000_00FC) begin
      n_fail++; $display("FAIL blt_flags: got v/t/lt=%b tgt=%h want 111 tgt=000000fc",
        {bus1.out_valid, bus1.taken, bus1.brlt}, bus1.target);
    end
    send(0, 3'b000, 32'h3, 32'h4, 32'hFFFF_FFF0, 32'h0000_0020);
    cycle();
    n_checks++;
    if (bus1.target !== 32'h0000_0010 || bus1.taken !== 1'b0) begin
      n_fail++; $display("FAIL target_wrap: got tgt=%h t=%b want tgt=00000010 t=0", bus1.target, bus1.taken);
    end
    idle(0);
    cycle();
    n_checks++;
    if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", bus1.out_valid); end
  endtask

  task automatic test_unsigned();
    send(0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h400, 32'h8);
    cycle();
    n_checks++;
    if ({bus1.out_valid, bus1.taken, bus1.brlt} !== 3'b100) begin
      n_fail++; $display("FAIL bltu_flags: got v/t/lt=%b want 100", {bus1.out_valid, bus1.taken, bus1.brlt});
    end
    send(0, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h404, 32'h8);
    cycle();
    n_checks++;
    if (bus1.taken !== 1'b1) begin n_fail++; $display("FAIL bgeu_taken: got %b want 1", bus1.taken); end
    send(0, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h408, 32'h8);
    cycle();
    n_checks++;
    if ({bus1.taken, bus1.brlt} !== 2'b01) begin
      n_fail++; $display("FAIL bge_signed: got t/lt=%b want 01", {bus1.taken, bus1.brlt});
    end
    idle(0);
    cycle();
  endtask

  task automatic test_illegal();
    send(0, 3'b010, 32'h7, 32'h7, 32'h500, 32'h4);
    cycle();
    n_checks++;
    if ({bus1.out_valid, bus1.illegal, bus1.taken, bus1.breq} !== 4'b1101) begin
      n_fail++; $display("FAIL illegal_010: got v/il/t/eq=%b want 1101",
        {bus1.out_valid, bus1.illegal, bus1.taken, bus1.breq});
    end
    send(0, 3'b011, 32'h1, 32'h2, 32'h504, 32'h4);
    cycle();
    n_checks++;
    if ({bus1.illegal, bus1.taken, bus1.brlt} !== 3'b101 || bus1.target !== 32'h508) begin
      n_fail++; $display("FAIL illegal_011: got il/t/lt=%b tgt=%h want 101 tgt=00000508",
        {bus1.illegal, bus1.taken, bus1.brlt}, bus1.target);
    end
    idle(0);
    cycle();
    cycle();
    // Eight requests retired so far on this instance, three of them taken
    n_checks++;
    if (bus1.br_count !== 16'd8 || bus1.br_count !== 16'(exp_br[0])) begin
      n_fail++; $display("FAIL br_count1: got %0d want 8 (model %0d)", bus1.br_count, exp_br[0]);
    end
    n_checks++;
    if (bus1.taken_count !== 16'd3 || bus1.taken_count !== 16'(exp_tk[0])) begin
      n_fail++; $display("FAIL taken_count1: got %0d want 3 (model %0d)", bus1.taken_count, exp_tk[0]);
    end
  endtask

  task automatic test_latency2_stall_flush();
    send(1, 3'b000, 32'h9, 32'h9, 32'h200, 32'h8);
    cycle();
    n_checks++;
    if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat2_early: got v=%b want 0", bus2.out_valid); end
    send(1, 3'b001, 32'h9, 32'h9, 32'h204, 32'h10);
    cycle();
    n_checks++;
    if ({bus2.out_valid, bus2.taken} !== 2'b11 || bus2.target !== 32'h208) begin
      n_fail++; $display("FAIL lat2_r0: got v/t=%b tgt=%h want 11 tgt=00000208",
        {bus2.out_valid, bus2.taken}, bus2.target);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h1, 32'h2, 32'h208, 32'h20);
      cycle();
      n_checks++;
      if ({bus2.out_valid, bus2.taken, bus2.breq} !== 3'b111 || bus2.target !== 32'h208) begin
        n_fail++; $display("FAIL stall_hold%0d: got v/t/eq=%b tgt=%h want 111 tgt=00000208",
          i, {bus2.out_valid, bus2.taken, bus2.breq}, bus2.target);
      end
    end
    send(1, 3'b100, 32'h1, 32'h2, 32'h208, 32'h20);
    cycle();
    n_checks++;
    if ({bus2.out_valid, bus2.taken} !== 2'b10 || bus2.target !== 32'h214) begin
      n_fail++; $display("FAIL lat2_r1: got v/t=%b tgt=%h want 10 tgt=00000214",
        {bus2.out_valid, bus2.taken}, bus2.target);
    end
    drive(1, 1'b1, 1'b0, 1'b1, 3'b111, 32'h2, 32'h1, 32'h20C, 32'h4);
    cycle();
    // The request sitting in stage 1 was killed by the flush
    void'(q2.pop_back());
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus2.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_valid%0d: got %b want 0", i, bus2.out_valid);
      end
      idle(1);
      cycle();
    end
    n_checks++;
    if (bus2.br_count !== 16'd2 || bus2.taken_count !== 16'd1) begin
      n_fail++; $display("FAIL lat2_counts: got %0d/%0d want 2/1", bus2.br_count, bus2.taken_count);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      send(2, 3'b001, 32'h1, 32'h2, 32'(i * 4), 32'h8);
      cycle();
    end
    idle(2);
    cycle();
    cycle();
    n_checks++;
    if (bus3.br_count !== 4'hF || bus3.taken_count !== 4'hF) begin
      n_fail++; $display("FAIL sat_counts: got %h/%h want f/f", bus3.br_count, bus3.taken_count);
    end
    cycle();
    n_checks++;
    if (bus3.br_count !== 4'(exp_br[2]) || bus3.taken_count !== 4'(exp_tk[2])) begin
      n_fail++; $display("FAIL sat_hold: got %h/%h want %h/%h",
        bus3.br_count, bus3.taken_count, exp_br[2], exp_tk[2]);
    end
  endtask

  task automatic test_reset_midop();
    send(1, 3'b000, 32'h1, 32'h1, 32'h600, 32'h4);
    cycle();
    send(1, 3'b000, 32'h2, 32'h2, 32'h604, 32'h4);
    cycle();
    rst = 1'b1;
    drive(1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    clear_model();
    n_checks++;
    if ({bus2.out_valid, bus2.taken, bus2.breq, bus2.brlt, bus2.illegal, bus2.target,
         bus2.br_count, bus2.taken_count} !== 69'h0) begin
      n_fail++; $display("FAIL midop_reset: got v=%b t=%b eq=%b tgt=%h cnt=%h/%h want all 0",
        bus2.out_valid, bus2.taken, bus2.breq, bus2.target, bus2.br_count, bus2.taken_count);
    end
    rst = 1'b0;
    idle(1);
    cycle();
    n_checks++;
    if (bus2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_ghost: got v=%b want 0", bus2.out_valid);
    end
    send(1, 3'b000, 32'h4, 32'h4, 32'h300, 32'h40);
    cycle();
    idle(1);
    cycle();
    n_checks++;
    if ({bus2.out_valid, bus2.taken} !== 2'b11 || bus2.target !== 32'h340) begin
      n_fail++; $display("FAIL post_reset_req: got v/t=%b tgt=%h want 11 tgt=00000340",
        {bus2.out_valid, bus2.taken}, bus2.target);
    end
    cycle();
    n_checks++;
    if (bus2.br_count !== 16'd1 || bus2.taken_count !== 16'd1) begin
      n_fail++; $display("FAIL post_reset_counts: got %0d/%0d want 1/1", bus2.br_count, bus2.taken_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq_blt();
    test_unsigned();
    test_illegal();
    test_latency2_stall_flush();
    test_saturate();
    test_reset_midop();
    cycle();
    n_checks++;
    if (q1.size() + q2.size() + q3.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d/%0d outstanding want 0/0/0",
        q1.size(), q2.size(), q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch resolution unit for the RV32I core's execute stage. It decodes all six conditional-branch funct3 encodings and compares rs1 against rs2, both signed and unsigned. It produces a registered taken/target result with valid, stall and flush control. It also keeps saturating branch and taken-branch event counters for performance monitoring.

## Interface
Parameters:
- XLEN, 32, operand and address width (8..64)
- LATENCY, 1, pipeline depth from input to result (1 or 2 only)
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request present this cycle
- stall  in  1  freeze every pipeline register and counter
- flush  in  1  kill every in-flight request, including this cycle's input
- funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- pc  in  XLEN  address of the branch instruction
- imm  in  XLEN  sign-extended B-type offset
- out_valid  out  1  result valid
- taken  out  1  branch condition true; forced to 0 when illegal
- target  out  XLEN  pc + imm, modulo 2^XLEN
- breq  out  1  rs1 == rs2
- brlt  out  1  rs1 < rs2, signed for funct3[1]=0 and unsigned for funct3[1]=1
- illegal  out  1  funct3 is 010 or 011
- br_count  out  CNT_W  count of retired valid requests
- taken_count  out  CNT_W  count of retired taken requests

## Operation
- Compare logic: breq = (rs1 == rs2). Let lt = $signed less-than when funct3[1]=0, else unsigned less-than.
- Condition: BEQ = breq, BNE = !breq, BLT/BLTU = lt, BGE/BGEU = !lt.
- Illegal funct3 (010, 011): illegal=1, taken=0. target is still computed.
- Target: computed in full XLEN with wrap-around, no carry out. For example, pc=FFFF_FFF0 and imm=0000_0020 give target 0000_0010.
- LATENCY=1: a single register stage holds valid, taken, breq, brlt, illegal and target.
- LATENCY=2:
  - Stage 1 registers the operands, pc, imm, funct3 and valid.
  - Stage 2 registers the results.
- Stall (stall=1, flush=0): every stage holds its contents and the counters hold. Inputs presented during a stall are ignored. The upstream stage must hold them stable.
- Flush: all stage valid bits clear on the next edge, and the input of the flush cycle is discarded. flush overrides stall.
- Result fields while out_valid=0 are don't-care, except during reset.
- Counters:
  - On each edge with out_valid=1 and stall=0, br_count increments.
  - taken_count increments on the same edge if taken=1.
  - Both saturate at all-ones and never wrap.
  - Flush does not clear the counters.
- Reset mid-operation: on an edge with rst=1, all valid bits, result outputs and counters clear. rst overrides flush and stall.

## Timing
- Reset value of every output is 0: out_valid, taken, target, breq, brlt, illegal, br_count, taken_count.
- Latency is LATENCY edges. An input accepted at edge N (in_valid=1, stall=0, flush=0) appears on the outputs after edge N+LATENCY-1+1.
  - LATENCY=1: the result is visible in the cycle after acceptance.
  - LATENCY=2: the result is visible two cycles after acceptance.
- Throughput is one request per cycle when stall=0.
- Each stall cycle adds exactly one cycle of latency to every in-flight request.
- Simultaneous flush and in_valid: no result is ever produced for that input.
- A counter increment is visible on the output the cycle after the retiring edge.
- No combinational path from any input to any output.

## Test plan
- BEQ and BLT in back-to-back cycles, XLEN=32, LATENCY=1:
  - BEQ with rs1=rs2=0x0000_0005 -> next cycle out_valid=1, taken=1, breq=1, brlt=0.
  - Then BLT with rs1=0xFFFF_FFFF (-1) and rs2=0x0000_0001 -> taken=1, brlt=1.
- BLTU with rs1=0xFFFF_FFFF, rs2=0x0000_0001 -> taken=0, brlt=0. BGEU with the same operands -> taken=1.
- funct3=010, rs1=rs2 -> illegal=1, taken=0, breq=1. br_count still increments and taken_count does not.
- LATENCY=2 stream of 4 requests with stall held for cycles 2-3:
  - Results emerge in order, each delayed by 2 cycles.
  - Outputs are stable during the stall.
  - Flush in cycle 5 removes both in-flight requests: out_valid=0 for the next 2 cycles.
- CNT_W=4: 20 taken BNE requests -> br_count=taken_count=0xF, held, no wrap.
- Reset mid-operation: rst asserted for one cycle while 2 requests are in flight and counters are nonzero -> next cycle all outputs 0. A new request then completes normally.
